// File: rtl/cluster_evt_pkg.sv
// Shared definitions for the cluster event transmit buffer:
// default geometry, the event payload type and a small width helper.
package cluster_evt_pkg;

    localparam int EVNT_WIDTH_DEF   = 8;
    localparam int BUFFER_WIDTH_DEF = 8;
    localparam int NB_SOURCES_DEF   = 4;

    typedef logic [EVNT_WIDTH_DEF-1:0] evt_t;

    // Width of an index into n items; never below one bit so that a
    // single-source build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cluster_evt_rr_arb.sv
// Round-robin arbiter. The grant is purely combinational from the request
// vector and the priority pointer; the pointer moves to the source after the
// granted one only when the caller signals that the grant was consumed.
module cluster_evt_rr_arb
    import cluster_evt_pkg::*;
#(
    parameter int NB_SOURCES = NB_SOURCES_DEF,
    localparam int IDX_W     = idx_width(NB_SOURCES)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [NB_SOURCES-1:0] req_i,
    input  logic                  adv_en_i,
    output logic [NB_SOURCES-1:0] grant_oh_o,
    output logic [IDX_W-1:0]      grant_idx_o,
    output logic                  grant_vld_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // First requesting source found when scanning upward from the pointer.
    always_comb begin
        int j;
        j           = 0;
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        for (int k = 0; k < NB_SOURCES; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NB_SOURCES) begin
                j = j - NB_SOURCES;
            end
            if (!grant_vld_o && req_i[j]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = IDX_W'(j);
            end
        end
        grant_oh_o = NB_SOURCES'(grant_vld_o) << grant_idx_o;
    end

    // Pointer advances past the winner only on a consumed grant.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_en_i) begin
            if (grant_idx_o == IDX_W'(NB_SOURCES - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + 1'b1;
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cluster_evt_tx_buf.sv
// Cluster event transmit buffer: arbitrates several event producers into a
// token-ring of slots read by a consumer in another clock domain. The
// consumer's one-hot read pointer is synchronised; the buffer is full when
// advancing the write token would land on that pointer, so one slot always
// stays empty.
// Optional stall statistics counter: define CLUSTER_EVT_TX_PERF_EN.
module cluster_evt_tx_buf
    import cluster_evt_pkg::*;
#(
    parameter int EVNT_WIDTH   = EVNT_WIDTH_DEF,
    parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
    parameter int NB_SOURCES   = NB_SOURCES_DEF
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NB_SOURCES-1:0]            evt_valid_i,
    input  logic [NB_SOURCES*EVNT_WIDTH-1:0] evt_data_i,
    output logic [NB_SOURCES-1:0]            evt_ready_o,
    output logic [BUFFER_WIDTH-1:0]          events_wt_o,
    input  logic [BUFFER_WIDTH-1:0]          events_rp_i,
    output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o
`ifdef CLUSTER_EVT_TX_PERF_EN
    ,
    input  logic                             stall_clr_i,
    output logic [15:0]                      stall_cnt_o
`endif
);

    localparam int IDX_W = idx_width(NB_SOURCES);

    // Refuse to build outside the supported geometry.
    if (BUFFER_WIDTH < 2 || BUFFER_WIDTH > 32) begin : g_bad_buffer_width
        $error("cluster_evt_tx_buf: BUFFER_WIDTH must be within 2..32");
    end
    if (NB_SOURCES < 1 || NB_SOURCES > 32) begin : g_bad_nb_sources
        $error("cluster_evt_tx_buf: NB_SOURCES must be within 1..32");
    end

    logic [BUFFER_WIDTH-1:0]            rp_meta_q, rp_meta_d;
    logic [BUFFER_WIDTH-1:0]            rp_sync_q, rp_sync_d;
    logic [BUFFER_WIDTH-1:0]            wt_q, wt_d;
    logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_q, da_d;

    logic [BUFFER_WIDTH-1:0] wt_rotl;
    logic                    full;
    logic                    accept;
    logic [NB_SOURCES-1:0]   grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_vld;
    logic [EVNT_WIDTH-1:0]   sel_data;

    assign wt_rotl = {wt_q[BUFFER_WIDTH-2:0], wt_q[BUFFER_WIDTH-1]};
    assign full    = (wt_rotl == rp_sync_q);

    // No acceptance while in reset, so a reset cycle can never half-write.
    assign accept      = grant_vld & ~full & rstn_i;
    assign evt_ready_o = grant_oh & {NB_SOURCES{accept}};

    assign events_wt_o = wt_q;
    assign events_da_o = da_q;

    cluster_evt_rr_arb #(
        .NB_SOURCES (NB_SOURCES)
    ) u_arb (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_i       (evt_valid_i),
        .adv_en_i    (accept),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // Payload of the granted source (one-hot select).
    always_comb begin
        sel_data = '0;
        for (int s = 0; s < NB_SOURCES; s++) begin
            if (grant_oh[s]) begin
                sel_data = evt_data_i[s*EVNT_WIDTH +: EVNT_WIDTH];
            end
        end
    end

    // Next state: synchroniser shift, token rotation and the single slot write.
    always_comb begin
        rp_meta_d = events_rp_i;
        rp_sync_d = rp_meta_q;
        wt_d      = accept ? wt_rotl : wt_q;
        da_d      = da_q;
        for (int k = 0; k < BUFFER_WIDTH; k++) begin
            if (accept && wt_q[k]) begin
                da_d[k*EVNT_WIDTH +: EVNT_WIDTH] = sel_data;
            end
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rp_meta_q <= BUFFER_WIDTH'(1);
            rp_sync_q <= BUFFER_WIDTH'(1);
            wt_q      <= BUFFER_WIDTH'(1);
            da_q      <= '0;
        end else begin
            rp_meta_q <= rp_meta_d;
            rp_sync_q <= rp_sync_d;
            wt_q      <= wt_d;
            da_q      <= da_d;
        end
    end

`ifdef CLUSTER_EVT_TX_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_o = stall_cnt_q;

    // Count cycles where a producer waits on a full ring; clear wins.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr_i) begin
            stall_cnt_d = '0;
        end else if ((|evt_valid_i) && full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_cluster_evt_tx_buf.sv
// Directed bench for cluster_evt_tx_buf (8-bit events, 8 slots, 4 sources).
module tb_cluster_evt_tx_buf;
    import cluster_evt_pkg::*;

    localparam int EW = 8;
    localparam int BW = 8;
    localparam int NS = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NS-1:0]     valid;
    logic [NS*EW-1:0]  data;
    logic [NS-1:0]     ready;
    logic [BW-1:0]     wt;
    logic [BW-1:0]     rp;
    logic [BW*EW-1:0]  da;
`ifdef CLUSTER_EVT_TX_PERF_EN
    logic              stall_clr;
    logic [15:0]       stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int order [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    cluster_evt_tx_buf #(
        .EVNT_WIDTH   (EW),
        .BUFFER_WIDTH (BW),
        .NB_SOURCES   (NS)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .evt_valid_i (valid),
        .evt_data_i  (data),
        .evt_ready_o (ready),
        .events_wt_o (wt),
        .events_rp_i (rp),
        .events_da_o (da)
`ifdef CLUSTER_EVT_TX_PERF_EN
        ,
        .stall_clr_i (stall_clr),
        .stall_cnt_o (stall_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input evt_t v);
        data[s*EW +: EW] = v;
    endtask

    task automatic do_reset;
        rstn  = 1'b0;
        valid = '0;
        tick();
        rstn  = 1'b1;
        #1;
    endtask

    initial begin
        rstn  = 1'b0;
        valid = '0;
        data  = '0;
        rp    = 8'h01;
`ifdef CLUSTER_EVT_TX_PERF_EN
        stall_clr = 1'b0;
`endif
        // Reset held two cycles, with a request pending to prove ready is gated.
        tick();
        valid = 4'b0001;
        set_src(0, 8'hA5);
        tick();
        #1;
        check_val("rst_wt", 64'(wt), 64'h01);
        check_val("rst_da", 64'(da), 64'h0);
        check_val("rst_rdy", 64'(ready), 64'h0);

        // Single write from source 0.
        rstn = 1'b1;
        #1;
        check_val("wr1_rdy", 64'(ready), 64'h1);
        tick();
        valid = '0;
        #1;
        check_val("wr1_da", 64'(da), 64'hA5);
        check_val("wr1_wt", 64'(wt), 64'h02);

        // Source 1 streams 8 events into an empty ring: 7 fit.
        do_reset();
        valid = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            set_src(1, evt_t'(8'h10 + i));
            #1;
            if (i < 7) begin
                check_val($sformatf("full_rdy%0d", i), 64'(ready), 64'h2);
            end else begin
                check_val("full_rdy_blk", 64'(ready), 64'h0);
                check_val("full_wt", 64'(wt), 64'h80);
            end
            tick();
        end
        check_val("full_da", 64'(da), 64'h0016151413121110);

        // Consumer frees slot 0: seen only after two synchroniser edges.
        rp = 8'h02;
        #1;
        check_val("rel_e0_rdy", 64'(ready), 64'h0);
        tick();
        check_val("rel_e1_rdy", 64'(ready), 64'h0);
        tick();
        check_val("rel_e2_rdy", 64'(ready), 64'h2);
        tick();
        check_val("rel_e3_wt", 64'(wt), 64'h01);
        check_val("rel_e3_rdy", 64'(ready), 64'h0);
        check_val("rel_e3_da", 64'(da), 64'h1716151413121110);
        valid = '0;

        // Fairness with all sources requesting.
        rp = 8'h01;
        do_reset();
        tick();
        tick();
        valid = 4'b1111;
        for (int s = 0; s < NS; s++) begin
            set_src(s, evt_t'(8'hC0 + s));
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val($sformatf("rr_grant%0d", k), 64'(ready), 64'(1) << order[k]);
            tick();
        end
        valid = 4'b1010;
        #1;
        check_val("rr_da", 64'(da), 64'h0000C1C0C3C2C1C0);
        check_val("rr_wt", 64'(wt), 64'h40);
        check_val("rr_skip", 64'(ready), 64'h8);
        tick();
        check_val("rr_full_blk", 64'(ready), 64'h0);
        valid = '0;

        // Mid-run reset with three slots filled.
        do_reset();
        valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            set_src(2, evt_t'(8'h31 + i));
            tick();
        end
        check_val("mid_wt", 64'(wt), 64'h08);
        check_val("mid_da", 64'(da), 64'h333231);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_rdy", 64'(ready), 64'h0);
        tick();
        check_val("mid_rst_wt", 64'(wt), 64'h01);
        check_val("mid_rst_da", 64'(da), 64'h0);
        rstn = 1'b1;

`ifdef CLUSTER_EVT_TX_PERF_EN
        // Fill the ring, then stall for five cycles.
        check_val("perf_rst", 64'(stall_cnt), 64'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_val("perf_fill_wt", 64'(wt), 64'h80);
        check_val("perf_fill_cnt", 64'(stall_cnt), 64'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_val("perf_cnt5", 64'(stall_cnt), 64'h5);
        stall_clr = 1'b1;
        tick();
        check_val("perf_clr", 64'(stall_cnt), 64'h0);
        stall_clr = 1'b0;
        tick();
        check_val("perf_after_clr", 64'(stall_cnt), 64'h1);
`endif
        valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
